// File: rtl/spu_ins_issue_if.sv
// Issue-buffer bus: per-pipe write handshake, execution stall, and the
// registered decoded fields handed to each pipe.
interface spu_ins_issue_if #(
   parameter int NUM_PIPES = 2,
   parameter int DEPTH     = 8,
   parameter int INS_W     = 57,
   parameter int OPC_W     = 11
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [NUM_PIPES-1:0]          wr_valid;
   logic [NUM_PIPES*INS_W-1:0]    wr_data;
   logic [NUM_PIPES-1:0]          wr_ready;
   logic [NUM_PIPES-1:0]          stall;
   logic [NUM_PIPES-1:0]          iss_valid;
   logic [NUM_PIPES*OPC_W-1:0]    iss_opcode;
   logic [NUM_PIPES*18-1:0]       iss_imm18;
   logic [NUM_PIPES*7-1:0]        iss_ra;
   logic [NUM_PIPES*7-1:0]        iss_rb;
   logic [NUM_PIPES*7-1:0]        iss_rc;
   logic [NUM_PIPES*7-1:0]        iss_rt;
   logic [NUM_PIPES*CW-1:0]       fill_cnt;

   modport master (
      output wr_valid, wr_data, stall,
      input  wr_ready, iss_valid, iss_opcode, iss_imm18,
             iss_ra, iss_rb, iss_rc, iss_rt, fill_cnt
   );

   modport slave (
      input  wr_valid, wr_data, stall,
      output wr_ready, iss_valid, iss_opcode, iss_imm18,
             iss_ra, iss_rb, iss_rc, iss_rt, fill_cnt
   );
endinterface

// File: rtl/spu_ins_issue.sv
// Multi-pipe SPU instruction issue buffer: per-pipe FIFOs, head decode, registered issue.
// Optional macro SPU_ISSUE_HAZARD_EN enables the intra-bundle RAW split.
module spu_ins_lane #(
   parameter int DEPTH = 8,
   parameter int INS_W = 57
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [INS_W-1:0]             wr_data,
   input  logic                         pop,
   output logic                         wr_ready,
   output logic                         nonempty,
   output logic [INS_W-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   fill_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [INS_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [CW-1:0]    cnt;
   logic             do_push, do_pop;

   // Ready comes from the registered count only, so a pop at full never frees a slot early.
   assign wr_ready = (cnt != CW'(DEPTH));
   assign nonempty = (cnt != '0);
   assign do_push  = push & wr_ready & ~flush;
   assign do_pop   = pop & nonempty & ~flush;
   assign head     = mem[rptr];
   assign fill_cnt = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wr_data;
   end
endmodule

module spu_ins_issue #(
   parameter int NUM_PIPES = 2,
   parameter int DEPTH     = 8,
   parameter int INS_W     = 57,
   parameter int OPC_W     = 11
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           lockstep,
   input  logic           flush,
   spu_ins_issue_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [OPC_W-1:0] opc;
      logic [17:0]      imm18;
      logic [6:0]       ra;
      logic [6:0]       rb;
      logic [6:0]       rc;
      logic [6:0]       rt;
   } iss_fields_t;

   logic [NUM_PIPES-1:0]            ready, nonempty, can_go, fire, iss_vld;
   logic [NUM_PIPES-1:0][INS_W-1:0] head;
   logic [NUM_PIPES-1:0][CW-1:0]    cnt;
   iss_fields_t [NUM_PIPES-1:0]     dec, iss_q;

   for (genvar p = 0; p < NUM_PIPES; p++) begin : g_lane
      spu_ins_lane #(.DEPTH(DEPTH), .INS_W(INS_W)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .push     (bus.wr_valid[p]),
         .wr_data  (bus.wr_data[p*INS_W +: INS_W]),
         .pop      (fire[p]),
         .wr_ready (ready[p]),
         .nonempty (nonempty[p]),
         .head     (head[p]),
         .fill_cnt (cnt[p])
      );
   end

   always_comb begin
      for (int p = 0; p < NUM_PIPES; p++) begin
         dec[p].opc   = head[p][INS_W-1 -: OPC_W];
         dec[p].imm18 = head[p][45:28];
         dec[p].ra    = head[p][27:21];
         dec[p].rb    = head[p][20:14];
         dec[p].rc    = head[p][13:7];
         dec[p].rt    = head[p][6:0];
      end
   end

   assign can_go = nonempty & ~bus.stall;

`ifdef SPU_ISSUE_HAZARD_EN
   logic [NUM_PIPES-1:0] split_q, split_d;

   // A pipe whose head reads the rt of a lower pipe issuing this cycle waits a cycle.
   // In lockstep the held-back entries then issue on their own before the bundle resumes.
   always_comb begin
      logic [NUM_PIPES-1:0] base, fv, hit;
      logic                 any_split;
      fire      = '0;
      split_d   = '0;
      base      = '0;
      fv        = '0;
      hit       = '0;
      any_split = lockstep & (|split_q);
      for (int q = 0; q < NUM_PIPES; q++) begin
         if (any_split)     base[q] = split_q[q] & can_go[q];
         else if (lockstep) base[q] = &can_go;
         else               base[q] = can_go[q];
         for (int p = 0; p < q; p++) begin
            if (fv[p] && (dec[q].ra == dec[p].rt || dec[q].rb == dec[p].rt ||
                          dec[q].rc == dec[p].rt))
               hit[q] = 1'b1;
         end
         fv[q] = base[q] & ~hit[q];
      end
      fire = fv;
      if (!lockstep)      split_d = '0;
      else if (any_split) split_d = split_q & ~fv;
      else                split_d = base & hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        split_q <= '0;
      else if (flush) split_q <= '0;
      else            split_q <= split_d;
   end
`else
   always_comb begin
      fire = can_go;
      if (lockstep) fire = {NUM_PIPES{&can_go}};
   end
`endif

   // Flush drops the valids but keeps the last issued fields visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_vld <= '0;
         iss_q   <= '0;
      end else if (flush) begin
         iss_vld <= '0;
      end else begin
         iss_vld <= fire;
         for (int p = 0; p < NUM_PIPES; p++)
            if (fire[p]) iss_q[p] <= dec[p];
      end
   end

   always_comb begin
      bus.iss_opcode = '0;
      bus.iss_imm18  = '0;
      bus.iss_ra     = '0;
      bus.iss_rb     = '0;
      bus.iss_rc     = '0;
      bus.iss_rt     = '0;
      for (int p = 0; p < NUM_PIPES; p++) begin
         bus.iss_opcode[p*OPC_W +: OPC_W] = iss_q[p].opc;
         bus.iss_imm18[p*18 +: 18]        = iss_q[p].imm18;
         bus.iss_ra[p*7 +: 7]             = iss_q[p].ra;
         bus.iss_rb[p*7 +: 7]             = iss_q[p].rb;
         bus.iss_rc[p*7 +: 7]             = iss_q[p].rc;
         bus.iss_rt[p*7 +: 7]             = iss_q[p].rt;
      end
   end

   assign bus.iss_valid = iss_vld;
   assign bus.wr_ready  = ready;
   assign bus.fill_cnt  = cnt;
endmodule

// File: tb/tb_spu_ins_issue.sv
// Directed bench for spu_ins_issue: reset, single issue, full/back-pressure,
// lockstep pairing, flush, mid-stream reset and the RAW split case.
module tb_spu_ins_issue;
   localparam int NP    = 2;
   localparam int DEPTH = 8;
   localparam int INS_W = 57;
   localparam int OPC_W = 11;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic lockstep = 1'b0;
   logic flush    = 1'b0;
   int   n_chk    = 0;
   int   n_err    = 0;

   spu_ins_issue_if #(.NUM_PIPES(NP), .DEPTH(DEPTH), .INS_W(INS_W), .OPC_W(OPC_W)) bus ();

   spu_ins_issue #(.NUM_PIPES(NP), .DEPTH(DEPTH), .INS_W(INS_W), .OPC_W(OPC_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .lockstep (lockstep),
      .flush    (flush),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [INS_W-1:0] mk(input logic [10:0] opc, input logic [17:0] imm,
                                            input logic [6:0] ra, input logic [6:0] rb,
                                            input logic [6:0] rc, input logic [6:0] rt);
      return {opc, imm, ra, rb, rc, rt};
   endfunction

   function automatic logic [10:0] opc_of(input int p);
      return bus.iss_opcode[p*OPC_W +: OPC_W];
   endfunction

   function automatic logic [CW-1:0] fill_of(input int p);
      return bus.fill_cnt[p*CW +: CW];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int p, input logic [INS_W-1:0] w);
      bus.wr_data[p*INS_W +: INS_W] = w;
      bus.wr_valid[p] = 1'b1;
   endtask

   initial begin
      bus.wr_valid = '0;
      bus.wr_data  = '0;
      bus.stall    = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(bus.iss_valid), 64'h0);
      chk("rst_ready", 64'(bus.wr_ready), 64'h3);
      chk("rst_fill", 64'(bus.fill_cnt), 64'h0);
      chk("rst_opc", 64'(bus.iss_opcode), 64'h0);
      chk("rst_rt", 64'(bus.iss_rt), 64'h0);
      rst = 1'b0;
      tick();

      // Single word on pipe0: accepted at edge N, issued at edge N+1
      put(0, mk(11'h0C0, 18'h0, 7'd3, 7'd4, 7'd0, 7'd5));
      tick();
      bus.wr_valid = '0;
      chk("t1_fill_after_wr", 64'(fill_of(0)), 64'd1);
      chk("t1_no_bypass", 64'(bus.iss_valid), 64'h0);
      tick();
      chk("t1_valid", 64'(bus.iss_valid), 64'h1);
      chk("t1_opc", 64'(opc_of(0)), 64'h0C0);
      chk("t1_ra", 64'(bus.iss_ra[6:0]), 64'd3);
      chk("t1_rb", 64'(bus.iss_rb[6:0]), 64'd4);
      chk("t1_rt", 64'(bus.iss_rt[6:0]), 64'd5);
      chk("t1_fill_empty", 64'(fill_of(0)), 64'd0);
      tick();
      chk("t1_valid_drop", 64'(bus.iss_valid), 64'h0);

      // Fill pipe1 under stall, overflow attempts, then drain in order
      bus.stall = 2'b10;
      for (int i = 0; i < 8; i++) begin
         put(1, mk(11'(11'h100 + i), 18'(i), 7'd30, 7'd31, 7'd32, 7'(40 + i)));
         tick();
      end
      chk("t2_ready_full", 64'(bus.wr_ready[1]), 64'h0);
      chk("t2_fill_full", 64'(fill_of(1)), 64'd8);
      chk("t2_stalled", 64'(bus.iss_valid), 64'h0);
      put(1, mk(11'h1EE, 18'h0, 7'd1, 7'd1, 7'd1, 7'd1));
      tick();
      chk("t2_ninth_ignored", 64'(fill_of(1)), 64'd8);
      bus.stall = 2'b00;
      put(1, mk(11'h1FF, 18'h0, 7'd1, 7'd1, 7'd1, 7'd1));
      tick();
      bus.wr_valid = '0;
      chk("t2_first_valid", 64'(bus.iss_valid), 64'h2);
      chk("t2_first_opc", 64'(opc_of(1)), 64'h100);
      chk("t2_no_slot_at_full", 64'(fill_of(1)), 64'd7);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("t2_burst_valid", 64'(bus.iss_valid), 64'h2);
         chk("t2_burst_opc", 64'(opc_of(1)), 64'(11'h100 + i));
      end
      chk("t2_last_imm", 64'(bus.iss_imm18[35:18]), 64'd7);
      tick();
      chk("t2_drained_valid", 64'(bus.iss_valid), 64'h0);
      chk("t2_drained_fill", 64'(fill_of(1)), 64'd0);
      chk("t2_ready_back", 64'(bus.wr_ready), 64'h3);

      // Lockstep: pipe0 waits until pipe1 has a word
      lockstep = 1'b1;
      put(0, mk(11'h300, 18'h0, 7'd20, 7'd21, 7'd22, 7'd1));
      tick();
      put(0, mk(11'h301, 18'h0, 7'd20, 7'd21, 7'd22, 7'd2));
      tick();
      bus.wr_valid = '0;
      tick();
      chk("t3_held", 64'(bus.iss_valid), 64'h0);
      chk("t3_fill0", 64'(fill_of(0)), 64'd2);
      put(1, mk(11'h311, 18'h0, 7'd10, 7'd11, 7'd12, 7'd13));
      tick();
      bus.wr_valid = '0;
      tick();
      chk("t3_pair_valid", 64'(bus.iss_valid), 64'h3);
      chk("t3_pair_opc0", 64'(opc_of(0)), 64'h300);
      chk("t3_pair_opc1", 64'(opc_of(1)), 64'h311);
      chk("t3_fill0_left", 64'(fill_of(0)), 64'd1);
      tick();
      chk("t3_alone_blocked", 64'(bus.iss_valid), 64'h0);
      lockstep = 1'b0;
      tick();
      chk("t3_indep_valid", 64'(bus.iss_valid), 64'h1);
      chk("t3_indep_opc", 64'(opc_of(0)), 64'h301);
      tick();

      // Flush with a concurrent write
      bus.stall = 2'b11;
      for (int i = 0; i < 4; i++) begin
         put(0, mk(11'(11'h400 + i), 18'h0, 7'd50, 7'd51, 7'd52, 7'd53));
         put(1, mk(11'(11'h410 + i), 18'h0, 7'd60, 7'd61, 7'd62, 7'd63));
         tick();
      end
      chk("t4_fill_pre", 64'(bus.fill_cnt), 64'h44);
      flush = 1'b1;
      put(0, mk(11'h4AA, 18'h0, 7'd1, 7'd1, 7'd1, 7'd1));
      put(1, mk(11'h4BB, 18'h0, 7'd1, 7'd1, 7'd1, 7'd1));
      tick();
      flush = 1'b0;
      bus.wr_valid = '0;
      chk("t4_fill_flushed", 64'(bus.fill_cnt), 64'h0);
      chk("t4_valid_flushed", 64'(bus.iss_valid), 64'h0);
      chk("t4_fields_hold", 64'(opc_of(0)), 64'h301);
      bus.stall = 2'b00;
      tick();
      tick();
      chk("t4_nothing_left", 64'(bus.iss_valid), 64'h0);
      chk("t4_write_dropped", 64'(bus.fill_cnt), 64'h0);

      // Asynchronous reset mid-stream
      bus.stall = 2'b01;
      for (int i = 0; i < 3; i++) begin
         put(0, mk(11'(11'h500 + i), 18'h0, 7'd70, 7'd71, 7'd72, 7'd73));
         tick();
      end
      bus.wr_valid = '0;
      chk("t5_fill3", 64'(fill_of(0)), 64'd3);
      bus.stall = 2'b00;
      tick();
      chk("t5_issue_pre", 64'(bus.iss_valid), 64'h1);
      chk("t5_opc_pre", 64'(opc_of(0)), 64'h500);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_valid", 64'(bus.iss_valid), 64'h0);
      chk("t5_rst_fill", 64'(bus.fill_cnt), 64'h0);
      chk("t5_rst_opc", 64'(bus.iss_opcode), 64'h0);
      chk("t5_rst_ready", 64'(bus.wr_ready), 64'h3);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_no_issue_after", 64'(bus.iss_valid), 64'h0);
      end

      // RAW between bundle slots: pipe1 reads pipe0's rt
      lockstep = 1'b1;
      put(0, mk(11'h2A0, 18'h0, 7'd1, 7'd2, 7'd3, 7'd9));
      put(1, mk(11'h2A1, 18'h0, 7'd9, 7'd4, 7'd5, 7'd6));
      tick();
      bus.wr_valid = '0;
      tick();
`ifdef SPU_ISSUE_HAZARD_EN
      chk("t6_split_first", 64'(bus.iss_valid), 64'h1);
      chk("t6_split_opc0", 64'(opc_of(0)), 64'h2A0);
      tick();
      chk("t6_split_second", 64'(bus.iss_valid), 64'h2);
      chk("t6_split_opc1", 64'(opc_of(1)), 64'h2A1);
`else
      chk("t6_pair_valid", 64'(bus.iss_valid), 64'h3);
      chk("t6_pair_opc0", 64'(opc_of(0)), 64'h2A0);
      chk("t6_pair_opc1", 64'(opc_of(1)), 64'h2A1);
`endif
      tick();
      chk("t6_idle", 64'(bus.iss_valid), 64'h0);
      chk("t6_empty", 64'(bus.fill_cnt), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/spu_ins_issue.md
Name: spu_ins_issue

Overview:
- Parametrised multi-pipe instruction issue buffer for the SPU pipes top.
- Accepts packed 57-bit instruction words per pipe (even, odd, ...) over a valid/ready handshake and buffers them in per-pipe FIFOs.
- Decodes the head word into opcode, register addresses and immediate, and issues registered fields to each pipe.
- Supports independent or lockstep (paired) issue, per-pipe stall and global flush. Generalises the fixed two-pipe, one-word-per-cycle instruction drive.

Parameters:
- NUM_PIPES, 2, number of issue channels (pipe 0 = even, pipe 1 = odd, ...)
- DEPTH, 8, FIFO entries per pipe, power of two, >= 2
- INS_W, 57, instruction word width
- OPC_W, 11, opcode field width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- lockstep  in  1  1 = issue all pipes together only; 0 = independent issue
- flush  in  1  synchronous clear of all FIFOs and issue registers
- wr_valid  in  NUM_PIPES  per-pipe write request
- wr_data  in  NUM_PIPES*INS_W  packed words; pipe p at [p*INS_W +: INS_W]
- wr_ready  out  NUM_PIPES  per-pipe FIFO not full
- stall  in  NUM_PIPES  per-pipe back-pressure from the execution pipe
- iss_valid  out  NUM_PIPES  issued-this-cycle flag
- iss_opcode  out  NUM_PIPES*OPC_W  word[56:46]
- iss_imm18  out  NUM_PIPES*18  word[45:28]; I16/I10/I8/I7 are its low bits
- iss_ra  out  NUM_PIPES*7  word[27:21]
- iss_rb  out  NUM_PIPES*7  word[20:14]
- iss_rc  out  NUM_PIPES*7  word[13:7]
- iss_rt  out  NUM_PIPES*7  word[6:0]
- fill_cnt  out  NUM_PIPES*$clog2(DEPTH+1)  per-pipe occupancy

Behaviour:
- Reset (async assert, sync release): pointers and fill_cnt = 0; iss_valid = 0; all iss_* fields = 0; wr_ready = all 1.
- Write: accepted for pipe p when wr_valid[p] && wr_ready[p]. wr_ready[p] = (fill_cnt[p] != DEPTH) and depends only on the registered count.
- At full, a simultaneous issue does not open a write slot the same cycle.
- Pointers wrap modulo DEPTH.
- Fire condition, per pipe: nonempty[p] && !stall[p].
  - lockstep=0: fire[p] = that condition.
  - lockstep=1: fire[p] = AND over all pipes of the condition (all fire or none).
- Issue on fire[p]:
  - Head word is popped.
  - Decoded fields are registered into iss_*[p].
  - iss_valid[p] = 1 on the next cycle.
- No fire: iss_valid[p] = 0 next cycle; fields hold their last value.
- Latency: a word accepted in cycle N with an empty FIFO appears with iss_valid in cycle N+2 (no write-to-issue bypass).
- Throughput: 1 word/pipe/cycle sustained.
- Simultaneous write and fire on a non-full FIFO: fill_cnt unchanged.
- Flush: takes priority over write and fire in the same cycle.
  - Next cycle: fill_cnt = 0, iss_valid = 0, fields hold their values.
  - Words presented during the flush cycle are dropped.
- Changing lockstep takes effect on the next fire evaluation; no state is lost.

Optional Feature:
- Macro: SPU_ISSUE_HAZARD_EN
- Defined: intra-bundle RAW split.
  - Pipe q is blocked if its head ra, rb or rc equals iss_rt-to-be of any lower-index pipe firing this cycle.
  - The blocked pipe retries next cycle. In lockstep, the split entry issues alone, waiving lockstep for that entry only.
  - Comparison covers all three source fields regardless of opcode, so it is conservative.
- Undefined: no comparison; fire rules as above.

Test Plan:
- Reset, lockstep=0, write pipe0 word {opc=11'h0C0, imm18=0, ra=3, rb=4, rc=0, rt=5} in cycle 2 -> iss_valid[0]=1 in cycle 4 with opcode 0x0C0, ra=3, rb=4, rt=5; iss_valid[1]=0 throughout.
- Write 8 words to pipe1 with stall[1]=1 -> wr_ready[1]=0 and fill_cnt[1]=8 after the 8th; a 9th write is ignored. Release stall -> 8 consecutive iss_valid[1] pulses in write order, then wr_ready=1.
- lockstep=1, pipe0 holds 2 words, pipe1 empty -> no issue. Write 1 word to pipe1 -> both pipes issue in the same cycle; pipe0 keeps 1 word.
- Fill both pipes with 4 words, assert flush together with a write -> fill_cnt=0 next cycle, iss_valid=0, written word dropped.
- Assert rst mid-stream with 3 words queued -> outputs immediately return to reset values and no issue occurs after release.
- SPU_ISSUE_HAZARD_EN defined, lockstep=1: pipe0 head rt=9, pipe1 head ra=9 -> pipe0 issues in cycle N, pipe1 in N+1. Without the macro -> both issue in cycle N.
